// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that time-shares one uart_tx serializer between N_REQ byte requesters.
// Define UART_ARB_LOCK_EN to add req_lock, which keeps multi-byte packets atomic.
module uart_tx_arb #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
   input  logic [N_REQ-1:0]   req_lock,
`endif
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic [ID_W-1:0]    grant_id,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   // Handshakes: a byte moves on a rising clk edge where valid && ready are both high.
   // req_ready depends on req_valid within the cycle; tx_valid never depends on tx_ready.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_LOW  = 2'd2,
      WAIT_HIGH = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] ptr_nxt;
   logic [ID_W-1:0] winner;
   logic [7:0]      winner_data;
   logic [N_REQ-1:0] pick;
   logic            winner_found;
   logic [ID_W-1:0] grant_inc;
   logic            hold_ptr;
   int              idx;

   // First valid requester at or above ptr, wrapping modulo N_REQ.
   always_comb begin
      winner       = '0;
      winner_data  = 8'h00;
      pick         = '0;
      winner_found = 1'b0;
      idx          = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!winner_found && req_valid[idx]) begin
            winner_found = 1'b1;
            winner       = ID_W'(idx);
            winner_data  = req_data[8*idx +: 8];
            pick[idx]    = 1'b1;
         end
      end
   end

   assign grant_inc = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

   // Holding ptr at grant_id also covers lock release: if that requester has gone
   // invalid the search from grant_id naturally lands on grant_id+1 onward.
`ifdef UART_ARB_LOCK_EN
   assign hold_ptr = req_lock[grant_id];
`else
   assign hold_ptr = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (winner_found) begin
               req_ready = pick;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (tx_ready) state_nxt = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!tx_ready) state_nxt = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (tx_ready) begin
               state_nxt = IDLE;
               ptr_nxt   = hold_ptr ? grant_id : grant_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         grant_id <= '0;
         tx_data  <= 8'h00;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         if (state == IDLE && winner_found) begin
            tx_data  <= winner_data;
            grant_id <= winner;
         end
      end
   end

   assign tx_valid  = (state == ISSUE);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

`ifndef SYNTHESIS
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
   a_ready_idle:   assert property (@(posedge clk) disable iff (!rst) (req_ready != '0) |-> (state == IDLE));
   a_issue_hold:   assert property (@(posedge clk) disable iff (!rst)
                      (state == ISSUE && !tx_ready) |=> (state == ISSUE && $stable(tx_data)));
`endif

endmodule
